// File: rtl/bus_port_endpoint.sv
// Per-port bus endpoint: FWFT TX FIFO toward the bus, FWFT RX FIFO toward the host,
// with destination checking and sticky error flags on the receive path.
module bus_port_endpoint #(
  parameter int unsigned pckg_sz = 16,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned ID      = 0,
  parameter logic [7:0]  BCAST   = 8'hFF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [pckg_sz-1:0]       wr_data,
  output logic                     tx_full,
  output logic [$clog2(DEPTH):0]   tx_count,
  output logic                     pndng,
  output logic [pckg_sz-1:0]       D_pop,
  input  logic                     pop,
  input  logic                     push,
  input  logic [pckg_sz-1:0]       D_push,
  input  logic                     rd_en,
  output logic                     rx_valid,
  output logic [pckg_sz-1:0]       rd_data,
  output logic [$clog2(DEPTH):0]   rx_count,
  output logic                     tx_ovf,
  output logic                     tx_udf,
  output logic                     rx_ovf,
  output logic                     misroute,
  output logic [7:0]               misroute_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [pckg_sz-1:0] tx_mem [DEPTH];
  logic [pckg_sz-1:0] rx_mem [DEPTH];
  logic [AW-1:0]      tx_wr_ptr, tx_rd_ptr, rx_wr_ptr, rx_rd_ptr;
  logic               rx_full;
  logic               tx_pop_ok, tx_wr_ok, rx_rd_ok, rx_wr_ok;
  logic [7:0]         dest;
  logic               dest_bad;

  always_comb begin
    tx_full  = (tx_count == CW'(DEPTH));
    pndng    = (tx_count != '0);
    D_pop    = pndng ? tx_mem[tx_rd_ptr] : '0;
    rx_full  = (rx_count == CW'(DEPTH));
    rx_valid = (rx_count != '0);
    rd_data  = rx_valid ? rx_mem[rx_rd_ptr] : '0;

    // A read frees a slot in the same edge, so a write at full is allowed alongside it.
    tx_pop_ok = pop && pndng;
    tx_wr_ok  = wr_en && (!tx_full || tx_pop_ok);
    rx_rd_ok  = rd_en && rx_valid;
    rx_wr_ok  = push && (!rx_full || rx_rd_ok);

    dest     = D_push[pckg_sz-1 -: 8];
    dest_bad = (dest != 8'(ID)) && (dest != BCAST);
  end

  always_ff @(posedge clk) begin
    if (tx_wr_ok) tx_mem[tx_wr_ptr] <= wr_data;
    if (rx_wr_ok) rx_mem[rx_wr_ptr] <= D_push;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_wr_ptr    <= '0;
      tx_rd_ptr    <= '0;
      tx_count     <= '0;
      rx_wr_ptr    <= '0;
      rx_rd_ptr    <= '0;
      rx_count     <= '0;
      tx_ovf       <= 1'b0;
      tx_udf       <= 1'b0;
      rx_ovf       <= 1'b0;
      misroute     <= 1'b0;
      misroute_cnt <= '0;
    end else begin
      if (tx_wr_ok)  tx_wr_ptr <= tx_wr_ptr + AW'(1);
      if (tx_pop_ok) tx_rd_ptr <= tx_rd_ptr + AW'(1);
      tx_count <= tx_count + CW'(tx_wr_ok) - CW'(tx_pop_ok);

      if (rx_wr_ok) rx_wr_ptr <= rx_wr_ptr + AW'(1);
      if (rx_rd_ok) rx_rd_ptr <= rx_rd_ptr + AW'(1);
      rx_count <= rx_count + CW'(rx_wr_ok) - CW'(rx_rd_ok);

      if (wr_en && !tx_wr_ok) tx_ovf <= 1'b1;
      if (pop && !pndng)      tx_udf <= 1'b1;
      if (push && !rx_wr_ok)  rx_ovf <= 1'b1;

      if (push && dest_bad) begin
        misroute <= 1'b1;
        if (misroute_cnt != 8'hFF) misroute_cnt <= misroute_cnt + 8'd1;
      end
    end
  end

endmodule
